// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DIGIT_W = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step: add 3 when the digit is 5 or more, so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d_in,
    output logic [DIGIT_W-1:0] d_out
);

    always_comb begin
        d_out = (d_in >= DIGIT_W'(5)) ? d_in + DIGIT_W'(3) : d_in;
    end

endmodule

// File: rtl/bcd_conv_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with optional two's-complement input and saturation on decimal overflow.
module bcd_conv_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W     = 16,
    parameter int DIGITS    = 5,
    parameter int SIGNED_EN = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [BIN_W-1:0]           bin_in,
    input  logic                       signed_mode,
    output logic                       busy,
    output logic                       done,
    output logic [DIGIT_W*DIGITS-1:0]  bcd_out,
    output logic                       neg,
    output logic                       overflow
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = clog2(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   mag_q, mag_d;
    logic [BCD_W-1:0]   dig_q, dig_d;
    logic               neg_r_q, neg_r_d;
    logic               ovf_r_q, ovf_r_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;

    logic signed [BIN_W-1:0] bin_s;
    logic                    is_neg;
    logic [BIN_W-1:0]        mag_in;
    logic [BCD_W-1:0]        dig_adj;
    logic [BCD_W-1:0]        dig_shift;
    logic [BIN_W-1:0]        mag_shift;
    logic                    shout;
    logic                    ovf_next;

    function automatic logic [BCD_W-1:0] saturate(input logic [BCD_W-1:0] d,
                                                  input logic ovf);
        return ovf ? {DIGITS{4'h9}} : d;
    endfunction

    // Negating the most negative value wraps to 2^(BIN_W-1), which is the correct magnitude.
    assign bin_s  = signed'(bin_in);
    assign is_neg = (SIGNED_EN != 0) && signed_mode && bin_in[BIN_W-1];
    assign mag_in = is_neg ? unsigned'(-bin_s) : bin_in;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        bcd_digit_adj u_adj (
            .d_in  (dig_q[i*DIGIT_W +: DIGIT_W]),
            .d_out (dig_adj[i*DIGIT_W +: DIGIT_W])
        );
    end

    assign shout     = dig_adj[BCD_W-1];
    assign dig_shift = {dig_adj[BCD_W-2:0], mag_q[BIN_W-1]};
    assign mag_shift = {mag_q[BIN_W-2:0], 1'b0};
    assign ovf_next  = ovf_r_q | shout;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mag_d   = mag_q;
        dig_d   = dig_q;
        neg_r_d = neg_r_q;
        ovf_r_d = ovf_r_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    mag_d   = mag_in;
                    dig_d   = '0;
                    neg_r_d = is_neg;
                    ovf_r_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                mag_d   = mag_shift;
                dig_d   = dig_shift;
                ovf_r_d = ovf_next;
                cnt_d   = cnt_q + CNT_W'(1);
                // The last shift publishes its result on the same edge.
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    bcd_d   = saturate(dig_shift, ovf_next);
                    neg_d   = neg_r_q;
                    ovf_d   = ovf_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mag_q   <= '0;
            dig_q   <= '0;
            neg_r_q <= 1'b0;
            ovf_r_q <= 1'b0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mag_q   <= mag_d;
            dig_q   <= dig_d;
            neg_r_q <= neg_r_d;
            ovf_r_q <= ovf_r_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);
    assign bcd_out  = bcd_q;
    assign neg      = neg_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Randomised and directed bench for bcd_conv_seq: three instances (5 digits
// signed, 4 digits signed, 5 digits unsigned-only) checked against a decimal model.
module tb_bcd_conv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bin_in = '0;
    logic        signed_mode = 1'b0;

    logic        d5_busy, d5_done, d5_neg, d5_ovf;
    logic [19:0] d5_bcd;
    logic        d4_busy, d4_done, d4_neg, d4_ovf;
    logic [15:0] d4_bcd;
    logic        du_busy, du_done, du_neg, du_ovf;
    logic [19:0] du_bcd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bcd_conv_seq #(.BIN_W(16), .DIGITS(5), .SIGNED_EN(1)) u_d5 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .signed_mode(signed_mode), .busy(d5_busy), .done(d5_done),
        .bcd_out(d5_bcd), .neg(d5_neg), .overflow(d5_ovf)
    );

    bcd_conv_seq #(.BIN_W(16), .DIGITS(4), .SIGNED_EN(1)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .signed_mode(signed_mode), .busy(d4_busy), .done(d4_done),
        .bcd_out(d4_bcd), .neg(d4_neg), .overflow(d4_ovf)
    );

    bcd_conv_seq #(.BIN_W(16), .DIGITS(5), .SIGNED_EN(0)) u_du (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .signed_mode(signed_mode), .busy(du_busy), .done(du_done),
        .bcd_out(du_bcd), .neg(du_neg), .overflow(du_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {overflow, neg, bcd[19:0]} from plain decimal arithmetic.
    function automatic logic [21:0] ref_model(input logic [15:0] b, input bit sgn, input int digits);
        int unsigned mag;
        int unsigned lim;
        bit          n;
        bit          ovf;
        logic [19:0] bcd;
        n   = sgn && b[15];
        mag = n ? (32'd65536 - 32'(b)) : 32'(b);
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        ovf = (mag >= lim);
        bcd = '0;
        for (int i = 0; i < digits; i++) begin
            if (ovf) begin
                bcd[4*i +: 4] = 4'h9;
            end else begin
                bcd[4*i +: 4] = 4'(mag % 10);
                mag = mag / 10;
            end
        end
        return {ovf, n, bcd};
    endfunction

    // Called at a negedge with the DUTs ready; returns at the negedge of the done cycle.
    task automatic conv(input logic [15:0] b, input logic sm, input bit keep, input bit glitch);
        logic [19:0] prev5;
        logic [21:0] e5, e4, eu;
        bit          got;
        int          n;
        prev5 = d5_bcd;
        e5 = ref_model(b, sm, 5);
        e4 = ref_model(b, sm, 4);
        eu = ref_model(b, 1'b0, 5);
        start = 1'b1;
        bin_in = b;
        signed_mode = sm;
        @(posedge clk);
        #1;
        if (!keep) start = 1'b0;
        got = 0;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            n = k;
            if (glitch && k == 5) start = 1'b1;
            if (glitch && k == 6) start = 1'b0;
            chk("busy_done_excl", 32'(d5_busy & d5_done), 32'd0);
            if (d5_done) begin
                got = 1;
                break;
            end
            chk("busy_during", 32'(d5_busy), 32'd1);
            chk("hold_during", 32'(d5_bcd), 32'(prev5));
        end
        if (!got) chk("done_timeout", 32'd0, 32'd1);
        chk("latency", 32'(n), 32'd16);
        chk("d4_done_sync", 32'(d4_done), 32'd1);
        chk("du_done_sync", 32'(du_done), 32'd1);
        chk("d5_bcd", 32'(d5_bcd), 32'(e5[19:0]));
        chk("d5_neg", 32'(d5_neg), 32'(e5[20]));
        chk("d5_ovf", 32'(d5_ovf), 32'(e5[21]));
        chk("d4_bcd", 32'(d4_bcd), 32'(e4[15:0]));
        chk("d4_neg", 32'(d4_neg), 32'(e4[20]));
        chk("d4_ovf", 32'(d4_ovf), 32'(e4[21]));
        chk("du_bcd", 32'(du_bcd), 32'(eu[19:0]));
        chk("du_neg", 32'(du_neg), 32'd0);
        chk("du_ovf", 32'(du_ovf), 32'(eu[21]));
        if (!keep) begin
            @(negedge clk);
            chk("done_width", 32'(d5_done), 32'd0);
            chk("idle_after", 32'(d5_busy), 32'd0);
        end
    endtask

    initial begin
        int nd;
        bit kp;
        #2;
        chk("rst_busy", 32'(d5_busy), 32'd0);
        chk("rst_done", 32'(d5_done), 32'd0);
        chk("rst_bcd", 32'(d5_bcd), 32'd0);
        chk("rst_neg", 32'(d5_neg), 32'd0);
        chk("rst_ovf", 32'(d5_ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        conv(16'hFFFF, 1'b0, 0, 0);
        chk("t1_bcd", 32'(d5_bcd), 32'h65535);
        chk("t1_neg", 32'(d5_neg), 32'd0);

        conv(16'h8000, 1'b1, 0, 0);
        chk("t2_bcd", 32'(d5_bcd), 32'h32768);
        chk("t2_neg", 32'(d5_neg), 32'd1);
        conv(16'hFFFF, 1'b1, 0, 0);
        chk("t2b_bcd", 32'(d5_bcd), 32'h00001);
        chk("t2b_neg", 32'(d5_neg), 32'd1);

        conv(16'd12345, 1'b0, 0, 0);
        chk("t3_ovf", 32'(d4_ovf), 32'd1);
        chk("t3_bcd", 32'(d4_bcd), 32'h9999);
        conv(16'd9999, 1'b0, 0, 0);
        chk("t3b_ovf", 32'(d4_ovf), 32'd0);
        chk("t3b_bcd", 32'(d4_bcd), 32'h9999);

        conv(16'd1234, 1'b0, 0, 1);
        chk("t4_bcd", 32'(d5_bcd), 32'h01234);
        conv(16'd4321, 1'b0, 1, 0);
        conv(16'd777, 1'b1, 0, 0);
        chk("t4b_bcd", 32'(d5_bcd), 32'h00777);

        start = 1'b1;
        bin_in = 16'd4321;
        signed_mode = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_bcd", 32'(d5_bcd), 32'd0);
        chk("arst_busy", 32'(d5_busy), 32'd0);
        chk("arst_done", 32'(d5_done), 32'd0);
        chk("arst_neg", 32'(d5_neg), 32'd0);
        chk("arst_ovf", 32'(d4_ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (d5_done) nd++;
        end
        chk("no_done_after_rst", 32'(nd), 32'd0);
        conv(16'd0, 1'b1, 0, 0);
        chk("t5_bcd", 32'(d5_bcd), 32'd0);
        chk("t5_neg", 32'(d5_neg), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            kp = ($urandom_range(0, 3) == 0) && (i != 2999);
            conv(16'($urandom), 1'($urandom_range(0, 1)), kp, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
